// File: rtl/push_conditioner.sv
// Pushbutton front end: optional 2-flop synchroniser (PUSH_SYNC_EN), per-button
// debounce, rising-edge pulses, and a one-hot key encoder with multi-press flag.
module push_conditioner #(
  parameter int N_BTN     = 14,
  parameter int DB_CYCLES = 4,
  parameter int CODE_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTN-1:0]  push_raw,
  output logic [N_BTN-1:0]  btn_level,
  output logic [N_BTN-1:0]  pulse,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              multi_err
);

  localparam int              CNT_W    = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_BTN-1:0] samp;

`ifdef PUSH_SYNC_EN
  logic [N_BTN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= push_raw;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = push_raw;
`endif

  // Debounce state: accepted level and run length of differing samples.
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (samp[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = samp[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edge history lags stable by one cycle so the pulse lands the cycle after acceptance.
  logic [N_BTN-1:0] hist_q;
  logic [N_BTN-1:0] pulse_d;

  assign pulse_d = stable_q & ~hist_q;

  // Encoder: classify the next pulse vector as none / exactly one / several.
  logic              any_hit;
  logic              many_hit;
  logic [CODE_W-1:0] hit_idx;
  logic              key_valid_d;
  logic [CODE_W-1:0] key_code_d;

  always_comb begin
    any_hit  = 1'b0;
    many_hit = 1'b0;
    hit_idx  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (pulse_d[i]) begin
        if (any_hit) many_hit = 1'b1;
        any_hit = 1'b1;
        hit_idx = CODE_W'(i);
      end
    end
    key_valid_d = any_hit & ~many_hit;
    key_code_d  = key_valid_d ? hit_idx : '0;
  end

  logic [N_BTN-1:0]  pulse_q;
  logic              key_valid_q;
  logic [CODE_W-1:0] key_code_q;
  logic              multi_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q    <= '0;
      hist_q      <= '0;
      pulse_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      multi_err_q <= 1'b0;
      // NOTE: cnt_q is a bank of individual flops, not a RAM, so clearing every
      // entry in reset is legal and required to discard partial debounce counts.
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      stable_q    <= stable_d;
      hist_q      <= stable_q;
      pulse_q     <= pulse_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      multi_err_q <= many_hit;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level = stable_q;
  assign pulse     = pulse_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign multi_err = multi_err_q;

endmodule

// File: tb/tb_push_conditioner.sv
// Self-checking bench for push_conditioner (DB_CYCLES=4, synchroniser off):
// a spec-level reference model feeds a scoreboard queue, plus a vector table.
module tb_push_conditioner;

  localparam int N  = 14;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  push_raw;
  logic [N-1:0]  btn_level;
  logic [N-1:0]  pulse;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          multi_err;

  push_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .CODE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .push_raw  (push_raw),
    .btn_level (btn_level),
    .pulse     (pulse),
    .key_valid (key_valid),
    .key_code  (key_code),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
    logic         vld;
    logic [3:0]   code;
    logic         err;
  } out_t;

  typedef struct {
    logic         r;
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
    logic         vld;
    logic [3:0]   code;
    logic         err;
  } vec_t;

  out_t   exp_q[$];
  int     n_vec  = 0;
  int     n_miss = 0;
  out_t   act;

  // Reference model: accepted level, run of consecutive differing samples,
  // and a pending-rise flag that becomes the pulse one edge later.
  logic [N-1:0] m_lvl  = '0;
  logic [N-1:0] m_pend = '0;
  int           m_run [N];

  task automatic model_step(input logic r, input logic [N-1:0] raw);
    out_t e;
    int   ones;
    e.pls  = '0;
    e.vld  = 1'b0;
    e.code = '0;
    e.err  = 1'b0;
    if (r) begin
      m_lvl  = '0;
      m_pend = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      e.pls  = m_pend;
      m_pend = '0;
      for (int i = 0; i < N; i++) begin
        if (raw[i] == m_lvl[i]) m_run[i] = 0;
        else m_run[i] = m_run[i] + 1;
        if (m_run[i] == DB) begin
          m_lvl[i] = raw[i];
          m_run[i] = 0;
          if (raw[i]) m_pend[i] = 1'b1;
        end
      end
      ones = $countones(e.pls);
      if (ones == 1) begin
        e.vld = 1'b1;
        for (int i = 0; i < N; i++) if (e.pls[i]) e.code = 4'(i);
      end
      e.err = (ones >= 2);
    end
    e.lvl = m_lvl;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input out_t a, input out_t e);
    n_vec++;
    if (a.lvl !== e.lvl || a.pls !== e.pls || a.vld !== e.vld ||
        a.code !== e.code || a.err !== e.err) begin
      n_miss++;
      $display("FAIL %s: got lvl=%h pls=%h vld=%b code=%0d err=%b, want lvl=%h pls=%h vld=%b code=%0d err=%b",
               name, a.lvl, a.pls, a.vld, a.code, a.err, e.lvl, e.pls, e.vld, e.code, e.err);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  // Drive one cycle, push the model expectation, compare after the edge.
  task automatic apply(input string name, input logic r, input logic [N-1:0] raw);
    out_t e;
    @(negedge clk);
    reset    = r;
    push_raw = raw;
    model_step(r, raw);
    @(posedge clk);
    #1;
    act.lvl  = btn_level;
    act.pls  = pulse;
    act.vld  = key_valid;
    act.code = key_code;
    act.err  = multi_err;
    e = exp_q.pop_front();
    check(name, act, e);
  endtask

  vec_t tbl [19];

  initial begin
    int p_cnt;
    int first_idx;
    out_t te;
    logic [N-1:0] cur;
    logic         r;

    reset    = 1'b1;
    push_raw = '0;

    // Reset state, then a long quiet interval.
    apply("reset", 1'b1, '0);
    for (int i = 0; i < 20; i++) apply("idle", 1'b0, '0);

    // Single press (bit 3), simultaneous press (bits 0 and 13), release all.
    tbl[0]  = '{1'b1, 14'h0000, 14'h0000, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 14'h0000, 14'h0000, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 14'h0008, 14'h0000, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{1'b0, 14'h0008, 14'h0000, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{1'b0, 14'h0008, 14'h0000, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[5]  = '{1'b0, 14'h0008, 14'h0008, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{1'b0, 14'h0008, 14'h0008, 14'h0008, 1'b1, 4'd3, 1'b0};
    tbl[7]  = '{1'b0, 14'h0008, 14'h0008, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[8]  = '{1'b0, 14'h2009, 14'h0008, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[9]  = '{1'b0, 14'h2009, 14'h0008, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[10] = '{1'b0, 14'h2009, 14'h0008, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[11] = '{1'b0, 14'h2009, 14'h2009, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[12] = '{1'b0, 14'h2009, 14'h2009, 14'h2001, 1'b0, 4'd0, 1'b1};
    tbl[13] = '{1'b0, 14'h2009, 14'h2009, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[14] = '{1'b0, 14'h0000, 14'h2009, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[15] = '{1'b0, 14'h0000, 14'h2009, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[16] = '{1'b0, 14'h0000, 14'h2009, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[17] = '{1'b0, 14'h0000, 14'h0000, 14'h0000, 1'b0, 4'd0, 1'b0};
    tbl[18] = '{1'b0, 14'h0000, 14'h0000, 14'h0000, 1'b0, 4'd0, 1'b0};

    for (int v = 0; v < 19; v++) begin
      apply($sformatf("tbl_model[%0d]", v), tbl[v].r, tbl[v].raw);
      te.lvl  = tbl[v].lvl;
      te.pls  = tbl[v].pls;
      te.vld  = tbl[v].vld;
      te.code = tbl[v].code;
      te.err  = tbl[v].err;
      check($sformatf("tbl[%0d]", v), act, te);
    end

    // Bit 5: a 3-cycle burst is rejected.
    p_cnt = 0;
    for (int i = 0; i < 3; i++) begin apply("b5_short", 1'b0, 14'h0020); p_cnt += int'(pulse[5]); end
    for (int i = 0; i < 6; i++) begin apply("b5_low",   1'b0, 14'h0000); p_cnt += int'(pulse[5]); end
    check_int("b5_short_pulses", p_cnt, 0);
    check_int("b5_short_level", int'(btn_level[5]), 0);

    // Bit 5: high 2, low 1, high 4 -> only the final run is accepted.
    p_cnt = 0;
    for (int i = 0; i < 2; i++) begin apply("b5_run1", 1'b0, 14'h0020); p_cnt += int'(pulse[5]); end
    apply("b5_gap", 1'b0, 14'h0000); p_cnt += int'(pulse[5]);
    for (int i = 0; i < 6; i++) begin apply("b5_run2", 1'b0, 14'h0020); p_cnt += int'(pulse[5]); end
    for (int i = 0; i < 6; i++) begin apply("b5_rel",  1'b0, 14'h0000); p_cnt += int'(pulse[5]); end
    check_int("b5_glitch_pulses", p_cnt, 1);

    // Bit 7: press then release, one pulse, none on release.
    p_cnt = 0;
    for (int i = 0; i < 6; i++) begin apply("b7_press", 1'b0, 14'h0080); p_cnt += int'(pulse[7]); end
    for (int i = 0; i < 6; i++) begin apply("b7_rel",   1'b0, 14'h0000); p_cnt += int'(pulse[7]); end
    check_int("b7_pulses", p_cnt, 1);
    check_int("b7_level_after_release", int'(btn_level[7]), 0);

    // Bit 9: reset two samples into a debounce while the button stays held.
    apply("b9_pre", 1'b0, 14'h0200);
    apply("b9_pre", 1'b0, 14'h0200);
    apply("b9_reset", 1'b1, 14'h0200);
    check_int("b9_reset_pulse", int'(pulse), 0);
    first_idx = -1;
    for (int i = 0; i < 8; i++) begin
      apply("b9_post", 1'b0, 14'h0200);
      if (pulse[9] && first_idx < 0) first_idx = i;
    end
    check_int("b9_pulse_edge", first_idx, DB);
    for (int i = 0; i < 6; i++) apply("b9_rel", 1'b0, 14'h0000);

    // Random slowly-varying buttons with occasional reset.
    cur = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      r = ($urandom_range(0, 79) == 0);
      apply("random", r, cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
